lut_neuron_array: RTL and testbench

LUT_NEURON_ARRAY -- requirements
Module: lut_neuron_array

---
 rtl/lut_neuron_pkg.sv | 14 +
 rtl/lut_neuron_ram.sv | 22 ++
 rtl/lut_neuron_array.sv | 138 +++++++++++++
 tb/tb_lut_neuron_array.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_neuron_pkg.sv
// Shared definitions for the LUT neuron array: FSM state encoding and default sizes.
package lut_neuron_pkg;

  localparam int unsigned DEF_IN_W   = 8;
  localparam int unsigned DEF_OUT_W  = 1;
  localparam int unsigned DEF_N_NEUR = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/lut_neuron_ram.sv
// Per-neuron lookup table: one synchronous write port, one asynchronous read port.
module lut_neuron_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_array.sv
// N_NEUR parallel LUT neurons behind a two-stage valid/ready pipeline with a LOAD/RUN/DRAIN
// table-reload FSM. Optional per-entry even parity: define LUT_NEURON_PARITY_EN.
module lut_neuron_array
  import lut_neuron_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned N_NEUR = DEF_N_NEUR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_NEUR*IN_W-1:0]    in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_NEUR*OUT_W-1:0]   out_data,
  input  logic                      cfg_start,
  input  logic                      cfg_done,
  input  logic                      cfg_we,
  // One spare code point so an out-of-range neuron index stays representable.
  input  logic [$clog2(N_NEUR+1)-1:0] cfg_neur,
  input  logic [IN_W-1:0]           cfg_addr,
  input  logic [OUT_W-1:0]          cfg_data,
  output logic                      loading
`ifdef LUT_NEURON_PARITY_EN
  , output logic                    par_err
`endif
);

  localparam int unsigned NSEL_W = $clog2(N_NEUR+1);
  localparam logic [NSEL_W-1:0] N_LIM = NSEL_W'(N_NEUR);
`ifdef LUT_NEURON_PARITY_EN
  localparam int unsigned WORD_W = OUT_W + 1;
`else
  localparam int unsigned WORD_W = OUT_W;
`endif

  state_t                     state;
  logic                       va, vb;
  logic [N_NEUR*IN_W-1:0]     da;
  logic [N_NEUR*OUT_W-1:0]    lookup;
  logic                       b_adv, in_fire, wr_ok;
`ifdef LUT_NEURON_PARITY_EN
  logic [N_NEUR-1:0]          bad;
`endif

  assign b_adv     = !vb || out_ready;
  assign in_ready  = (state == RUN) && (!va || !vb || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign wr_ok     = cfg_we && (state == LOAD) && (cfg_neur < N_LIM);
  assign out_valid = vb;

  for (genvar k = 0; k < N_NEUR; k++) begin : g_neur
    logic              we_k;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;

    assign we_k = wr_ok && (cfg_neur == NSEL_W'(k));
`ifdef LUT_NEURON_PARITY_EN
    assign wdata  = {^cfg_data, cfg_data};
    assign bad[k] = rdata[OUT_W] != (^rdata[OUT_W-1:0]);
`else
    assign wdata  = cfg_data;
`endif

    lut_neuron_ram #(
      .AW(IN_W),
      .DW(WORD_W)
    ) u_ram (
      .clk   (clk),
      .we    (we_k),
      .waddr (cfg_addr),
      .wdata (wdata),
      .raddr (da[k*IN_W +: IN_W]),
      .rdata (rdata)
    );

    assign lookup[k*OUT_W +: OUT_W] = rdata[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      loading <= 1'b1;
    end else begin
      case (state)
        LOAD: if (cfg_done) begin
          state   <= RUN;
          loading <= 1'b0;
        end
        RUN: if (cfg_start) state <= DRAIN;
        DRAIN: if (!va && !vb) begin
          state   <= LOAD;
          loading <= 1'b1;
        end
        default: begin
          state   <= LOAD;
          loading <= 1'b1;
        end
      endcase
    end
  end

  // Stage A only accepts when its word can move on (in_ready), so va is freed whenever B advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va       <= 1'b0;
      vb       <= 1'b0;
      da       <= '0;
      out_data <= '0;
    end else begin
      if (in_fire) begin
        va <= 1'b1;
        da <= in_data;
      end else if (b_adv) begin
        va <= 1'b0;
      end
      if (b_adv) begin
        vb <= va;
        if (va) out_data <= lookup;
      end
    end
  end

`ifdef LUT_NEURON_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (state == DRAIN && !va && !vb) begin
      par_err <= 1'b0;
    end else if (b_adv && va && (|bad)) begin
      par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lut_neuron_array.sv
// Self-checking bench for lut_neuron_array against a table model; parity scenario when
// LUT_NEURON_PARITY_EN is defined.
module tb_lut_neuron_array;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 1;
  localparam int unsigned N     = 4;
  localparam int unsigned DW    = N*IN_W;
  localparam int unsigned OW    = N*OUT_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          cfg_start = 1'b0;
  logic          cfg_done = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_neur = '0;
  logic [IN_W-1:0]  cfg_addr = '0;
  logic [OUT_W-1:0] cfg_data = '0;
  logic          loading;
`ifdef LUT_NEURON_PARITY_EN
  logic          par_err;
  logic          s_pe;
`endif

  int nvec = 0;
  int nerr = 0;
  logic s_ir, s_ov, s_ld;

  logic [OUT_W-1:0] tbl [N][256];

  lut_neuron_array #(.IN_W(IN_W), .OUT_W(OUT_W), .N_NEUR(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_start(cfg_start), .cfg_done(cfg_done), .cfg_we(cfg_we),
    .cfg_neur(cfg_neur), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .loading(loading)
`ifdef LUT_NEURON_PARITY_EN
    , .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] expect_word(input logic [DW-1:0] w);
    logic [OW-1:0] r;
    for (int k = 0; k < N; k++) r[k*OUT_W +: OUT_W] = tbl[k][w[k*IN_W +: IN_W]];
    return r;
  endfunction

  // One clock: sample handshakes at the falling edge, return #1 after the next rising edge.
  task automatic step(output logic acc, output logic dlv, output logic [OW-1:0] od);
    @(negedge clk);
    acc  = in_valid && in_ready;
    dlv  = out_valid && out_ready;
    od   = out_data;
    s_ir = in_ready;
    s_ov = out_valid;
    s_ld = loading;
`ifdef LUT_NEURON_PARITY_EN
    s_pe = par_err;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic lookup_one(input logic [DW-1:0] w, output logic [OW-1:0] r, output logic ok);
    logic acc, dlv, sent;
    logic [OW-1:0] od;
    sent = 1'b0; ok = 1'b0; r = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 8 && !ok; c++) begin
      in_valid = !sent;
      in_data  = w;
      step(acc, dlv, od);
      if (acc) sent = 1'b1;
      if (dlv) begin r = od; ok = 1'b1; end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    nvec++; if (loading !== 1'b1) begin nerr++; $display("FAIL rst_loading got=%b exp=1", loading); end
    nvec++; if (out_data !== '0) begin nerr++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_infer();
    logic acc, dlv;
    logic [OW-1:0] od, e;
    logic [OW-1:0] q[$];
    logic [DW-1:0] words[256];
    logic [7:0] av;
    int sent, got, miss, t_acc, t_first, t_last;
    for (int k = 0; k < N; k++)
      for (int a = 0; a < 256; a++) begin
        av = 8'(a);
        tbl[k][a] = OUT_W'((($countones(av) % 2) != 0) ^ ((k % 2) != 0));
        cfg_we = 1'b1; cfg_neur = 3'(k); cfg_addr = av; cfg_data = tbl[k][a];
        cfg_done = (k == N-1) && (a == 255);
        step(acc, dlv, od);
      end
    cfg_we = 1'b0; cfg_done = 1'b0;
    nvec++; if (loading !== 1'b0) begin nerr++; $display("FAIL load_exit loading got=%b exp=0", loading); end
    for (int i = 0; i < 256; i++) words[i] = DW'($urandom);
    sent = 0; got = 0; miss = 0; t_acc = -1; t_first = -1; t_last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 400 && got < 256; c++) begin
      in_valid = (sent < 256);
      if (sent < 256) in_data = words[sent];
      step(acc, dlv, od);
      if (in_valid && !acc) miss++;
      if (acc) begin
        q.push_back(expect_word(in_data));
        if (sent == 0) t_acc = c;
        sent++;
      end
      if (dlv) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        nvec++; if (od !== e) begin nerr++; $display("FAIL stream_data word=%0d got=%h exp=%h", got, od, e); end
        if (got == 0) t_first = c;
        t_last = c;
        got++;
      end
    end
    in_valid = 1'b0;
    nvec++; if (got != 256) begin nerr++; $display("FAIL stream_count got=%0d exp=256", got); end
    nvec++; if (t_first != t_acc + 2) begin nerr++; $display("FAIL stream_latency got=%0d exp=%0d", t_first, t_acc + 2); end
    nvec++; if (t_last != t_first + 255) begin nerr++; $display("FAIL stream_rate last=%0d exp=%0d", t_last, t_first + 255); end
    nvec++; if (miss != 0) begin nerr++; $display("FAIL stream_in_ready stalls got=%0d exp=0", miss); end
  endtask

  task automatic test_backpressure();
    logic acc, dlv, stall, have_held;
    logic [OW-1:0] od, e, held;
    logic [OW-1:0] q[$];
    int sent, got, stall_acc;
    sent = 0; got = 0; stall_acc = 0; have_held = 1'b0; held = '0;
    for (int c = 0; c < 80 && (sent < 24 || got < sent); c++) begin
      stall     = (c >= 8) && (c <= 12);
      out_ready = !stall;
      in_valid  = (sent < 24) && (c != 6) && (c != 7);
      in_data   = DW'($urandom);
      step(acc, dlv, od);
      if (acc) begin
        q.push_back(expect_word(in_data));
        sent++;
        if (stall) stall_acc++;
      end
      if (stall && s_ov) begin
        if (!have_held) begin held = od; have_held = 1'b1; end
        else begin
          nvec++; if (od !== held) begin nerr++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, od, held); end
        end
      end
      if (c == 12) begin
        nvec++; if (s_ir !== 1'b0) begin nerr++; $display("FAIL bp_in_ready got=%b exp=0", s_ir); end
      end
      if (dlv) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        nvec++; if (od !== e) begin nerr++; $display("FAIL bp_data word=%0d got=%h exp=%h", got, od, e); end
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    nvec++; if (stall_acc != 2) begin nerr++; $display("FAIL bp_accepts_in_stall got=%0d exp=2", stall_acc); end
    nvec++; if (!have_held) begin nerr++; $display("FAIL bp_valid_in_stall got=0 exp=1"); end
    nvec++; if (got != 24) begin nerr++; $display("FAIL bp_count got=%0d exp=24", got); end
  endtask

  task automatic test_reload();
    logic acc, dlv, seen, ok;
    logic [OW-1:0] od, e, r;
    logic [OW-1:0] q[$];
    logic [7:0] x;
    logic [DW-1:0] w;
    int got;
    x = 8'($urandom_range(0, 255));
    got = 0; seen = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = DW'($urandom);
      step(acc, dlv, od);
      if (acc) q.push_back(expect_word(in_data));
    end
    nvec++; if (q.size() != 2) begin nerr++; $display("FAIL reload_accepts got=%0d exp=2", q.size()); end
    in_valid = 1'b0; cfg_start = 1'b1;
    step(acc, dlv, od);
    if (dlv) begin
      e = (q.size() > 0) ? q.pop_front() : 'x;
      nvec++; if (od !== e) begin nerr++; $display("FAIL reload_data got=%h exp=%h", od, e); end
      got++;
    end
    cfg_start = 1'b0;
    in_valid = 1'b1; in_data = DW'($urandom);
    cfg_we = 1'b1; cfg_neur = 3'd0; cfg_addr = x; cfg_data = ~tbl[0][x];
    for (int c = 0; c < 12 && !seen; c++) begin
      step(acc, dlv, od);
      cfg_we = 1'b0;
      if (dlv) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        nvec++; if (od !== e) begin nerr++; $display("FAIL reload_data got=%h exp=%h", od, e); end
        got++;
      end
      if (s_ld) begin
        seen = 1'b1;
        nvec++; if (got != 2) begin nerr++; $display("FAIL reload_delivered_before_load got=%0d exp=2", got); end
      end else begin
        nvec++; if (s_ir !== 1'b0) begin nerr++; $display("FAIL drain_in_ready got=%b exp=0", s_ir); end
      end
    end
    in_valid = 1'b0;
    nvec++; if (!seen) begin nerr++; $display("FAIL reload_loading timeout got=0 exp=1"); end
    cfg_done = 1'b1; step(acc, dlv, od); cfg_done = 1'b0;
    w = DW'($urandom); w[7:0] = x;
    lookup_one(w, r, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL reload_lookup timeout"); end
    nvec++; if (r !== expect_word(w)) begin nerr++; $display("FAIL drain_write_dropped got=%h exp=%h", r, expect_word(w)); end
    cfg_start = 1'b1; step(acc, dlv, od); cfg_start = 1'b0;
    for (int c = 0; c < 6 && !loading; c++) step(acc, dlv, od);
    nvec++; if (loading !== 1'b1) begin nerr++; $display("FAIL reload_empty_to_load got=%b exp=1", loading); end
  endtask

  task automatic test_illegal_index();
    logic acc, dlv, ok;
    logic [OW-1:0] od, r;
    logic [7:0] y;
    logic [DW-1:0] w;
    y = 8'($urandom_range(0, 255));
    cfg_we = 1'b1; cfg_neur = 3'd5; cfg_addr = y; cfg_data = ~tbl[1][y];
    step(acc, dlv, od);
    cfg_we = 1'b0;
    cfg_done = 1'b1; step(acc, dlv, od); cfg_done = 1'b0;
    w = {y, y, y, y};
    lookup_one(w, r, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL illegal_lookup timeout"); end
    nvec++; if (r !== expect_word(w)) begin nerr++; $display("FAIL illegal_index_write got=%h exp=%h", r, expect_word(w)); end
  endtask

  task automatic test_mid_reset();
    logic acc, dlv, ok;
    logic [OW-1:0] od, r;
    logic [DW-1:0] w;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = DW'($urandom);
      step(acc, dlv, od);
    end
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL mr_pipeline_full got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mr_out_valid got=%b exp=0", out_valid); end
    nvec++; if (loading !== 1'b1) begin nerr++; $display("FAIL mr_loading got=%b exp=1", loading); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL mr_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(acc, dlv, od);
      nvec++; if (s_ov !== 1'b0) begin nerr++; $display("FAIL mr_no_output cyc=%0d got=%b exp=0", c, s_ov); end
      nvec++; if (s_ld !== 1'b1) begin nerr++; $display("FAIL mr_state_load cyc=%0d got=%b exp=1", c, s_ld); end
    end
    cfg_done = 1'b1; step(acc, dlv, od); cfg_done = 1'b0;
    w = DW'($urandom);
    lookup_one(w, r, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL mr_lookup timeout"); end
    nvec++; if (r !== expect_word(w)) begin nerr++; $display("FAIL mr_table_kept got=%h exp=%h", r, expect_word(w)); end
  endtask

`ifdef LUT_NEURON_PARITY_EN
  task automatic test_parity();
    logic acc, dlv;
    logic [OW-1:0] od, e;
    logic [OW-1:0] q[$];
    logic [DW-1:0] words[3];
    int sent, got;
    nvec++; if (par_err !== 1'b0) begin nerr++; $display("FAIL par_initial got=%b exp=0", par_err); end
    dut.g_neur[2].u_ram.mem[8'h55][OUT_W] = ~dut.g_neur[2].u_ram.mem[8'h55][OUT_W];
    for (int i = 0; i < 3; i++) begin
      words[i] = DW'($urandom);
      words[i][23:16] = (i == 1) ? 8'h55 : 8'h54;
    end
    sent = 0; got = 0; out_ready = 1'b1;
    for (int c = 0; c < 12 && (got < 3 || c < 8); c++) begin
      in_valid = (sent < 3);
      if (sent < 3) in_data = words[sent];
      step(acc, dlv, od);
      if (acc) begin q.push_back(expect_word(in_data)); sent++; end
      if (got >= 2) begin
        nvec++; if (s_pe !== 1'b1) begin nerr++; $display("FAIL par_sticky cyc=%0d got=%b exp=1", c, s_pe); end
      end
      if (dlv) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        nvec++; if (od !== e) begin nerr++; $display("FAIL par_data word=%0d got=%h exp=%h", got, od, e); end
        nvec++; if (s_pe !== (got >= 1)) begin nerr++; $display("FAIL par_err word=%0d got=%b exp=%b", got, s_pe, got >= 1); end
        got++;
      end
    end
    in_valid = 1'b0;
    nvec++; if (got != 3) begin nerr++; $display("FAIL par_count got=%0d exp=3", got); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_infer();
    test_backpressure();
    test_reload();
    test_illegal_index();
    test_mid_reset();
`ifdef LUT_NEURON_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
